sc_io_bank: RTL and testbench

- Parametrised memory-mapped I/O subsystem for the single-cycle CPU top level.
- Replaces the fixed 8-switch input port and single hard-wired seven-segment digit with three functions:
  - a debounced, synchronised switch input port;
  - a writable output port shown on NUM_DIGITS seven-segment digits in hex or decimal;
  - a status register.
- Decimal display uses a sequential double-dabble converter, so the CPU polls a busy flag.
- Sits between the CPU data bus (I/O address space) and the board switches/HEX displays.

---
 rtl/sc_io_pkg.sv | 53 +++++
 rtl/sc_io_bank_if.sv | 11 +
 rtl/sc_bin2bcd.sv | 91 +++++++++
 rtl/sc_io_bank.sv | 153 +++++++++++++++
 tb/tb_sc_io_bank.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/sc_io_pkg.sv
// Shared definitions for the CPU I/O bank: register offsets, converter states,
// segment constants and the hex segment decoder.
package sc_io_pkg;

    localparam logic [1:0] REG_IN     = 2'd0;
    localparam logic [1:0] REG_OUT    = 2'd1;
    localparam logic [1:0] REG_MODE   = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } conv_state_e;

    localparam logic [6:0] SEG_ZERO = 7'h40;
    localparam logic [6:0] SEG_DASH = 7'h3F;

    // Active-low {g..a} pattern for one hex nibble.
    function automatic logic [6:0] seg_of_nibble(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            4'hF:    seg = 7'h0E;
            default: seg = SEG_DASH;
        endcase
        return seg;
    endfunction

    function automatic logic [63:0] pow10(input int unsigned n);
        logic [63:0] p;
        p = 64'd1;
        for (int unsigned i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

endpackage

// File: rtl/sc_io_bank_if.sv
// CPU-side I/O bus into the I/O bank: select, write strobe, address and data.
interface sc_io_bank_if;
    logic        io_sel;
    logic        io_we;
    logic [1:0]  io_addr;
    logic [31:0] io_wdata;
    logic [31:0] io_rdata;

    modport master (output io_sel, output io_we, output io_addr, output io_wdata, input io_rdata);
    modport slave  (input io_sel, input io_we, input io_addr, input io_wdata, output io_rdata);
endinterface

// File: rtl/sc_bin2bcd.sv
// Sequential double-dabble: one shift/add-3 step per cycle, restartable by start,
// cancelled by abort; done is high for the single cycle spent in DONE.
module sc_bin2bcd
    import sc_io_pkg::*;
#(
    parameter int BIN_W      = 16,
    parameter int NUM_DIGITS = 4
) (
    input  logic                    clock,
    input  logic                    resetn,
    input  logic                    start_i,
    input  logic                    abort_i,
    input  logic [BIN_W-1:0]        value_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [4*NUM_DIGITS-1:0] bcd_o
);
    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    conv_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [BIN_W-1:0] bin_q, bin_d;
    logic [BCD_W-1:0] bcd_q, bcd_d;
    logic [BCD_W-1:0] adj_s;

    // add-3 correction applied to every digit before the shift
    always_comb begin
        adj_s = bcd_q;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (bcd_q[4*k +: 4] >= 4'd5) begin
                adj_s[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
            end else begin
                adj_s[4*k +: 4] = bcd_q[4*k +: 4];
            end
        end
    end

    // next-state and datapath; a new start always wins over abort and the current step
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        if (start_i) begin
            state_d = ST_CONV;
            cnt_d   = {CNT_W{1'b0}};
            bin_d   = value_i;
            bcd_d   = {BCD_W{1'b0}};
        end else if (abort_i) begin
            state_d = ST_IDLE;
            cnt_d   = {CNT_W{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_IDLE;
                ST_CONV: begin
                    bcd_d = {adj_s[BCD_W-2:0], bin_q[BIN_W-1]};
                    bin_d = {bin_q[BIN_W-2:0], 1'b0};
                    if (cnt_q == CNT_W'(BIN_W - 1)) begin
                        state_d = ST_DONE;
                        cnt_d   = {CNT_W{1'b0}};
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // converter state register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            bin_q   <= {BIN_W{1'b0}};
            bcd_q   <= {BCD_W{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
        end
    end

    assign busy_o = (state_q != ST_IDLE);
    assign done_o = (state_q == ST_DONE);
    assign bcd_o  = bcd_q;

endmodule

// File: rtl/sc_io_bank.sv
// Memory-mapped I/O bank: debounced switch port, hex/decimal seven-segment
// output register and status flags for the single-cycle CPU.
module sc_io_bank
    import sc_io_pkg::*;
#(
    parameter int SW_WIDTH   = 8,
    parameter int NUM_DIGITS = 4,
    parameter int BIN_W      = 16,
    parameter int DB_TICKS   = 50000
) (
    input  logic                    clock,
    input  logic                    resetn,
    sc_io_bank_if.slave             bus,
    input  logic [SW_WIDTH-1:0]     switch,
    output logic [7*NUM_DIGITS-1:0] seg_out,
    output logic                    busy
);
    localparam int          TCNT_W    = $clog2(DB_TICKS);
    localparam int          EXT_W     = (4 * NUM_DIGITS > BIN_W) ? 4 * NUM_DIGITS : BIN_W;
    localparam int          SEG_W     = 7 * NUM_DIGITS;
    localparam logic [63:0] DEC_LIMIT = pow10(NUM_DIGITS);

    logic [SW_WIDTH-1:0]   sync1_q, sync2_q, sample_q, db_q, db_d;
    logic [TCNT_W-1:0]     tcnt_q;
    logic                  tick_s;
    logic [BIN_W-1:0]      out_q, new_out_s;
    logic                  mode_q, new_mode_s;
    logic                  ovf_q, new_ovf_s;
    logic [SEG_W-1:0]      seg_q, hex_seg_s, dec_seg_s;
    logic                  wr_out_s, wr_mode_s, trigger_s;
    logic                  conv_busy_s, conv_done_s;
    logic [4*NUM_DIGITS-1:0] bcd_s;
    logic [EXT_W-1:0]      ext_s;
    logic [31:0]           rdata_s;
    logic                  unused_wdata_s;

    assign tick_s = (tcnt_q == TCNT_W'(DB_TICKS - 1));
    // a bit only follows the synchronised input when two consecutive tick samples agree
    assign db_d   = (db_q & (sync2_q ^ sample_q)) | (sync2_q & ~(sync2_q ^ sample_q));

    // synchroniser, shared tick counter and debounced switch register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sync1_q  <= {SW_WIDTH{1'b0}};
            sync2_q  <= {SW_WIDTH{1'b0}};
            sample_q <= {SW_WIDTH{1'b0}};
            db_q     <= {SW_WIDTH{1'b0}};
            tcnt_q   <= {TCNT_W{1'b0}};
        end else begin
            sync1_q <= switch;
            sync2_q <= sync1_q;
            if (tick_s) begin
                tcnt_q   <= {TCNT_W{1'b0}};
                sample_q <= sync2_q;
                db_q     <= db_d;
            end else begin
                tcnt_q <= tcnt_q + TCNT_W'(1);
            end
        end
    end

    assign wr_out_s   = bus.io_sel && bus.io_we && (bus.io_addr == REG_OUT);
    assign wr_mode_s  = bus.io_sel && bus.io_we && (bus.io_addr == REG_MODE);
    assign trigger_s  = wr_out_s || wr_mode_s;
    assign new_out_s  = wr_out_s ? bus.io_wdata[BIN_W-1:0] : out_q;
    assign new_mode_s = wr_mode_s ? bus.io_wdata[0] : mode_q;
    assign ext_s      = EXT_W'(new_out_s);

    // overflow is judged on the value being rendered, in the mode it is rendered in
    always_comb begin
        new_ovf_s = 1'b0;
        if (new_mode_s) begin
            new_ovf_s = (64'(new_out_s) >= DEC_LIMIT);
        end else begin
            new_ovf_s = ((ext_s >> (4 * NUM_DIGITS)) != {EXT_W{1'b0}});
        end
    end

    // segment images for both render paths
    always_comb begin
        hex_seg_s = {SEG_W{1'b0}};
        dec_seg_s = {SEG_W{1'b0}};
        for (int k = 0; k < NUM_DIGITS; k++) begin
            hex_seg_s[7*k +: 7] = seg_of_nibble(ext_s[4*k +: 4]);
            if (ovf_q) begin
                dec_seg_s[7*k +: 7] = SEG_DASH;
            end else begin
                dec_seg_s[7*k +: 7] = seg_of_nibble(bcd_s[4*k +: 4]);
            end
        end
    end

    sc_bin2bcd #(
        .BIN_W      (BIN_W),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_bin2bcd (
        .clock   (clock),
        .resetn  (resetn),
        .start_i (trigger_s && new_mode_s),
        .abort_i (trigger_s && !new_mode_s),
        .value_i (new_out_s),
        .busy_o  (conv_busy_s),
        .done_o  (conv_done_s),
        .bcd_o   (bcd_s)
    );

    // register file, overflow flag and display registers
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            out_q  <= {BIN_W{1'b0}};
            mode_q <= 1'b0;
            ovf_q  <= 1'b0;
            seg_q  <= {NUM_DIGITS{SEG_ZERO}};
        end else begin
            out_q  <= new_out_s;
            mode_q <= new_mode_s;
            if (trigger_s) begin
                ovf_q <= new_ovf_s;
            end else begin
                ovf_q <= ovf_q;
            end
            if (trigger_s && !new_mode_s) begin
                seg_q <= hex_seg_s;
            end else if (conv_done_s && !trigger_s) begin
                seg_q <= dec_seg_s;
            end else begin
                seg_q <= seg_q;
            end
        end
    end

    // read mux
    always_comb begin
        rdata_s = 32'd0;
        if (bus.io_sel) begin
            case (bus.io_addr)
                REG_IN:     rdata_s = 32'(db_q);
                REG_OUT:    rdata_s = 32'(out_q);
                REG_MODE:   rdata_s = {31'd0, mode_q};
                REG_STATUS: rdata_s = {30'd0, ovf_q, conv_busy_s};
                default:    rdata_s = 32'd0;
            endcase
        end else begin
            rdata_s = 32'd0;
        end
    end

    assign bus.io_rdata   = rdata_s;
    assign seg_out        = seg_q;
    assign busy           = conv_busy_s;
    assign unused_wdata_s = ^bus.io_wdata;

endmodule

// File: tb/tb_sc_io_bank.sv
// Randomised self-checking bench for sc_io_bank against a behavioural model of
// the register map, render timing and switch debouncing.
module tb_sc_io_bank;
    localparam int ND = 4;
    localparam int BW = 16;
    localparam int DB = 4;
    localparam int SW = 8;

    logic          clock = 1'b0;
    logic          resetn = 1'b0;
    logic [SW-1:0] switch_s = '0;
    logic [7*ND-1:0] seg_s;
    logic          busy_s;

    sc_io_bank_if bus();

    sc_io_bank #(.SW_WIDTH(SW), .NUM_DIGITS(ND), .BIN_W(BW), .DB_TICKS(DB)) dut (
        .clock   (clock),
        .resetn  (resetn),
        .bus     (bus),
        .switch  (switch_s),
        .seg_out (seg_s),
        .busy    (busy_s)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // display / register model
    logic [15:0]     m_out = '0;
    logic            m_mode = 1'b0;
    logic            m_ovf = 1'b0;
    logic [7*ND-1:0] m_disp = {ND{7'h40}};
    logic [7*ND-1:0] m_pend = '0;
    int              m_rem = 0;

    // debounce model: tick every DB edges after reset, comparing the input seen two edges earlier
    int          dbn = 0;
    logic [SW-1:0] h1 = '0, h2 = '0, prev_m = '0, db_m = '0;

    function automatic logic [SW-1:0] db_next(input logic [SW-1:0] cur, input logic [SW-1:0] prev,
                                              input logic [SW-1:0] db);
        logic [SW-1:0] r;
        r = db;
        for (int b = 0; b < SW; b++) if (cur[b] == prev[b]) r[b] = cur[b];
        return r;
    endfunction

    always @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            dbn <= 0; h1 <= '0; h2 <= '0; prev_m <= '0; db_m <= '0;
        end else begin
            dbn <= dbn + 1;
            if ((dbn + 1) % DB == 0) begin
                db_m   <= db_next(h2, prev_m, db_m);
                prev_m <= h2;
            end
            h2 <= h1;
            h1 <= switch_s;
        end
    end

    function automatic logic [7*ND-1:0] hex_segs(input logic [15:0] v);
        logic [7*ND-1:0] r;
        logic [3:0] nib;
        for (int k = 0; k < ND; k++) begin
            nib = 4'((v >> (4 * k)) & 16'hF);
            r[7*k +: 7] = seg_tab[nib];
        end
        return r;
    endfunction

    function automatic logic [7*ND-1:0] dec_segs(input logic [15:0] v);
        logic [7*ND-1:0] r;
        int div;
        logic [3:0] d;
        div = 1;
        for (int k = 0; k < ND; k++) begin
            d = 4'((int'(v) / div) % 10);
            r[7*k +: 7] = seg_tab[d];
            div = div * 10;
        end
        return r;
    endfunction

    function automatic logic [31:0] exp_rdata(input logic sel, input logic [1:0] addr);
        if (!sel) return 32'd0;
        case (addr)
            2'd0:    return {24'd0, db_m};
            2'd1:    return {16'd0, m_out};
            2'd2:    return {31'd0, m_mode};
            default: return {30'd0, m_ovf, (m_rem != 0)};
        endcase
    endfunction

    task automatic model_trigger(input logic [1:0] addr, input logic [31:0] data);
        if (addr == 2'd1) m_out = data[15:0];
        else m_mode = data[0];
        if (!m_mode) begin
            m_disp = hex_segs(m_out);
            m_ovf  = 1'b0;  // sixteen bits always fit four hex digits
            m_rem  = 0;
        end else begin
            m_ovf  = (m_out >= 16'd10000);
            m_pend = m_ovf ? {ND{7'h3F}} : dec_segs(m_out);
            m_rem  = BW + 1;
        end
    endtask

    task automatic model_tick();
        if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0) m_disp = m_pend;
        end
    endtask

    task automatic model_reset();
        m_out = '0; m_mode = 1'b0; m_ovf = 1'b0; m_disp = {ND{7'h40}}; m_rem = 0;
    endtask

    // one clock cycle: drive at negedge, check read data, clock, then check outputs
    task automatic step(input logic sel, input logic we, input logic [1:0] addr,
                        input logic [31:0] data, input logic [SW-1:0] sw);
        bus.io_sel = sel; bus.io_we = we; bus.io_addr = addr; bus.io_wdata = data;
        switch_s = sw;
        #1;
        check_eq("rdata", bus.io_rdata, exp_rdata(sel, addr));
        @(posedge clock);
        if (sel && we && (addr == 2'd1 || addr == 2'd2)) model_trigger(addr, data);
        else model_tick();
        @(negedge clock);
        check_eq("seg_out", 32'(seg_s), 32'(m_disp));
        check_eq("busy", 32'(busy_s), 32'(m_rem != 0));
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 2'd3, 32'd0, switch_s);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40; i++) begin
            if (!busy_s) break;
            idle();
        end
        check_eq("idle_timeout", 32'(busy_s), 32'd0);
    endtask

    task automatic count_busy(input string tag);
        int cnt;
        cnt = busy_s ? 1 : 0;
        for (int i = 0; i < 40; i++) begin
            idle();
            if (busy_s) cnt++;
            else break;
        end
        check_eq(tag, cnt, 32'd17);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [SW-1:0] sw_cur;
        int r;
        bit found;
        bus.io_sel = 1'b0; bus.io_we = 1'b0; bus.io_addr = 2'd0; bus.io_wdata = 32'd0;
        repeat (3) @(negedge clock);
        check_eq("rst_seg", 32'(seg_s), 32'(28'h8102040));
        resetn = 1'b1;

        // 1: reset state
        idle();
        check_eq("t1_seg", 32'(seg_s), 32'(28'h8102040));
        check_eq("t1_status", bus.io_rdata, 32'd0);
        check_eq("t1_busy", 32'(busy_s), 32'd0);

        // 2: hex render
        step(1'b1, 1'b1, 2'd1, 32'h0000_1A2F, '0);
        check_eq("t2_seg", 32'(seg_s), 32'({7'h79, 7'h08, 7'h24, 7'h0E}));
        idle();
        check_eq("t2_status", bus.io_rdata, 32'd0);

        // 3: decimal render latency and result
        step(1'b1, 1'b1, 2'd2, 32'd1, '0);
        wait_idle();
        step(1'b1, 1'b1, 2'd1, 32'd1234, '0);
        count_busy("t3_busy_len");
        check_eq("t3_seg", 32'(seg_s), 32'({7'h79, 7'h24, 7'h30, 7'h19}));

        // 4: decimal overflow shows dashes
        step(1'b1, 1'b1, 2'd1, 32'd10000, '0);
        wait_idle();
        check_eq("t4_seg", 32'(seg_s), 32'({4{7'h3F}}));
        check_eq("t4_status", bus.io_rdata, 32'h2);

        // 5: retrigger mid-conversion restarts the window
        step(1'b1, 1'b1, 2'd1, 32'h10, '0);
        repeat (4) idle();
        step(1'b1, 1'b1, 2'd1, 32'd9, '0);
        count_busy("t5_busy_len");
        check_eq("t5_seg", 32'(seg_s), 32'({7'h40, 7'h40, 7'h40, 7'h10}));

        // 6: chatter rejected, stable level accepted; toggling starts on an odd edge
        while (dbn % 2 != 0) step(1'b1, 1'b0, 2'd0, 32'd0, '0);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, 2'd0, 32'd0, (i % 2 == 0) ? 8'h01 : 8'h00);
            check_eq("t6_toggle_in", bus.io_rdata, 32'd0);
        end
        found = 1'b0;
        for (int i = 0; i < 11; i++) begin
            step(1'b1, 1'b0, 2'd0, 32'd0, 8'h01);
            if (bus.io_rdata == 32'd1) begin
                found = 1'b1;
                break;
            end
        end
        check_eq("t6_hold_in", 32'(found), 32'd1);

        // randomised traffic
        sw_cur = 8'h01;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) sw_cur = 8'($urandom);
            r = $urandom_range(0, 9);
            case ($urandom_range(0, 2))
                0:       d = 32'($urandom_range(0, 9999));
                1:       d = 32'($urandom_range(0, 65535));
                default: d = $urandom;
            endcase
            if (r < 2)       step(1'b1, 1'b1, 2'd1, d, sw_cur);
            else if (r == 2) step(1'b1, 1'b1, 2'd2, $urandom, sw_cur);
            else if (r == 3) step(1'b1, 1'b1, ($urandom_range(0, 1) == 0) ? 2'd0 : 2'd3, d, sw_cur);
            else if (r <= 6) step(1'b1, 1'b0, 2'($urandom_range(0, 3)), d, sw_cur);
            else             step(1'b0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), d, sw_cur);
        end

        // asynchronous reset in the middle of a decimal conversion
        step(1'b1, 1'b1, 2'd2, 32'd1, sw_cur);
        step(1'b1, 1'b1, 2'd1, 32'd4321, sw_cur);
        repeat (5) idle();
        bus.io_sel = 1'b1; bus.io_we = 1'b0; bus.io_addr = 2'd3;
        #2 resetn = 1'b0;
        model_reset();
        #1;
        check_eq("arst_seg", 32'(seg_s), 32'(28'h8102040));
        check_eq("arst_busy", 32'(busy_s), 32'd0);
        check_eq("arst_status", bus.io_rdata, 32'd0);
        @(negedge clock);
        resetn = 1'b1;
        idle();
        step(1'b1, 1'b0, 2'd1, 32'd0, '0);
        step(1'b1, 1'b1, 2'd1, 32'h0000_BEEF, '0);
        check_eq("post_rst_hex", 32'(seg_s), 32'({7'h03, 7'h06, 7'h06, 7'h0E}));
        repeat (12) idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
